// File: rtl/alu_arbiter.sv
// Two-port valid/ready arbiter sharing one ALU (IDLE -> EXEC -> RESP).
// Define ALU_ARB_ZERO_FLAG_EN to add per-port result-is-zero outputs.
module alu_arbiter #(
  parameter bit FIXED_PRIORITY = 1'b0,
  parameter bit RR_INIT        = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_req_valid,
  output logic       a_req_ready,
  input  logic [2:0] a_opcode,
  input  logic [7:0] a_op1,
  input  logic [7:0] a_op2,
  output logic       a_rsp_valid,
  input  logic       a_rsp_ready,
  output logic [7:0] a_rsp_data,
  output logic       a_rsp_err,
  input  logic       b_req_valid,
  output logic       b_req_ready,
  input  logic [2:0] b_opcode,
  input  logic [7:0] b_op1,
  input  logic [7:0] b_op2,
  output logic       b_rsp_valid,
  input  logic       b_rsp_ready,
  output logic [7:0] b_rsp_data,
  output logic       b_rsp_err,
`ifdef ALU_ARB_ZERO_FLAG_EN
  output logic       a_rsp_zero,
  output logic       b_rsp_zero,
`endif
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t      state;
  logic        gnt;
  logic        ptr;
  logic [2:0]  opc_q;
  logic [7:0]  op1_q;
  logic [7:0]  op2_q;
  logic [7:0]  res_q;
  logic        err_q;

  logic        grant_a;
  logic        grant_b;
  logic        in_exec;
  logic        illegal;
  logic        rsp_hs;
  logic [7:0]  sel;
  logic [7:0]  alu_x;
  logic [7:0]  alu_y;
  logic [7:0]  alu_res;

  always_comb begin
    grant_a = 1'b0;
    if (FIXED_PRIORITY)
      grant_a = a_req_valid;
    else
      grant_a = a_req_valid &
                (~b_req_valid | ~ptr);
    grant_b = b_req_valid & ~grant_a;
  end

  assign in_exec = (state == EXEC);
  assign illegal = (opc_q == 3'd7);
  assign rsp_hs  = gnt ? b_rsp_ready
                       : a_rsp_ready;

  // ALU sees only latched operands, and only in EXEC
  assign alu_x = in_exec ? op1_q : '0;
  assign alu_y = in_exec ? op2_q : '0;

  always_comb begin
    sel = 8'h00;
    if (in_exec) begin
      unique case (opc_q)
        3'd0: sel = 8'h02;
        3'd1: sel = 8'h04;
        3'd2: sel = 8'h08;
        3'd3: sel = 8'h10;
        3'd4: sel = 8'h20;
        3'd5: sel = 8'h40;
        3'd6: sel = 8'h80;
        3'd7: sel = 8'h00;
      endcase
    end
  end

  always_comb begin
    alu_res = 8'h00;
    unique case (1'b1)
      sel[0]:  alu_res = 8'h00;
      sel[1]:  alu_res = alu_x + alu_y;
      sel[2]:  alu_res = alu_x - alu_y;
      sel[3]:  alu_res = alu_x + 8'd1;
      sel[4]:  alu_res = alu_x - 8'd1;
      sel[5]:  alu_res = alu_x & alu_y;
      sel[6]:  alu_res = alu_x | alu_y;
      sel[7]:  alu_res = ~alu_x;
      default: alu_res = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 1'b0;
      ptr   <= RR_INIT;
      opc_q <= '0;
      op1_q <= '0;
      op2_q <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_a | grant_b) begin
            gnt   <= grant_b;
            opc_q <= grant_b ? b_opcode : a_opcode;
            op1_q <= grant_b ? b_op1 : a_op1;
            op2_q <= grant_b ? b_op2 : a_op2;
            state <= EXEC;
          end
        end
        EXEC: begin
          res_q <= illegal ? 8'h00 : alu_res;
          err_q <= illegal;
          state <= RESP;
        end
        RESP: begin
          // pointer moves only on completion
          if (rsp_hs) begin
            ptr   <= ~gnt;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign a_req_ready = (state == IDLE) & grant_a;
  assign b_req_ready = (state == IDLE) & grant_b;
  assign a_rsp_valid = (state == RESP) & ~gnt;
  assign b_rsp_valid = (state == RESP) & gnt;
  assign a_rsp_data  = a_rsp_valid ? res_q : '0;
  assign b_rsp_data  = b_rsp_valid ? res_q : '0;
  assign a_rsp_err   = a_rsp_valid & err_q;
  assign b_rsp_err   = b_rsp_valid & err_q;

`ifdef ALU_ARB_ZERO_FLAG_EN
  logic zero_q;

  always_ff @(posedge clk) begin
    if (rst)
      zero_q <= 1'b0;
    else if (in_exec)
      zero_q <= ~illegal & (alu_res == 8'h00);
  end

  assign a_rsp_zero = a_rsp_valid & zero_q;
  assign b_rsp_zero = b_rsp_valid & zero_q;
`else
  // no zero-detect hardware in this build
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: single-port ops, arbitration,
// backpressure, illegal opcode and mid-operation reset.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_req_valid, b_req_valid;
  logic [2:0] a_opcode, b_opcode;
  logic [7:0] a_op1, a_op2, b_op1, b_op2;
  logic       a_rsp_ready, b_rsp_ready;

  logic       a_req_ready, b_req_ready;
  logic       a_rsp_valid, b_rsp_valid;
  logic [7:0] a_rsp_data, b_rsp_data;
  logic       a_rsp_err, b_rsp_err;
  logic       busy;

  logic       f_a_req_ready, f_b_req_ready;
  logic       f_a_rsp_valid, f_b_rsp_valid;
  logic [7:0] f_a_rsp_data, f_b_rsp_data;
  logic       f_a_rsp_err, f_b_rsp_err;
  logic       f_busy;
`ifdef ALU_ARB_ZERO_FLAG_EN
  logic       a_rsp_zero, b_rsp_zero;
  logic       f_a_rsp_zero, f_b_rsp_zero;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(
    .FIXED_PRIORITY(1'b0),
    .RR_INIT(1'b0)
  ) dut (
    .clk(clk), .rst(rst),
    .a_req_valid(a_req_valid),
    .a_req_ready(a_req_ready),
    .a_opcode(a_opcode),
    .a_op1(a_op1), .a_op2(a_op2),
    .a_rsp_valid(a_rsp_valid),
    .a_rsp_ready(a_rsp_ready),
    .a_rsp_data(a_rsp_data),
    .a_rsp_err(a_rsp_err),
    .b_req_valid(b_req_valid),
    .b_req_ready(b_req_ready),
    .b_opcode(b_opcode),
    .b_op1(b_op1), .b_op2(b_op2),
    .b_rsp_valid(b_rsp_valid),
    .b_rsp_ready(b_rsp_ready),
    .b_rsp_data(b_rsp_data),
    .b_rsp_err(b_rsp_err),
`ifdef ALU_ARB_ZERO_FLAG_EN
    .a_rsp_zero(a_rsp_zero),
    .b_rsp_zero(b_rsp_zero),
`endif
    .busy(busy)
  );

  alu_arbiter #(
    .FIXED_PRIORITY(1'b1),
    .RR_INIT(1'b0)
  ) dut_fp (
    .clk(clk), .rst(rst),
    .a_req_valid(a_req_valid),
    .a_req_ready(f_a_req_ready),
    .a_opcode(a_opcode),
    .a_op1(a_op1), .a_op2(a_op2),
    .a_rsp_valid(f_a_rsp_valid),
    .a_rsp_ready(a_rsp_ready),
    .a_rsp_data(f_a_rsp_data),
    .a_rsp_err(f_a_rsp_err),
    .b_req_valid(b_req_valid),
    .b_req_ready(f_b_req_ready),
    .b_opcode(b_opcode),
    .b_op1(b_op1), .b_op2(b_op2),
    .b_rsp_valid(f_b_rsp_valid),
    .b_rsp_ready(b_rsp_ready),
    .b_rsp_data(f_b_rsp_data),
    .b_rsp_err(f_b_rsp_err),
`ifdef ALU_ARB_ZERO_FLAG_EN
    .a_rsp_zero(f_a_rsp_zero),
    .b_rsp_zero(f_b_rsp_zero),
`endif
    .busy(f_busy)
  );

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    a_opcode = '0; a_op1 = '0; a_op2 = '0;
    b_opcode = '0; b_op1 = '0; b_op2 = '0;
    a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // one op on one port, rsp_ready held high
  task automatic run_op(input bit port,
                        input logic [2:0] opc,
                        input logic [7:0] x,
                        input logic [7:0] y,
                        input logic [7:0] exp,
                        input logic err,
                        input string tag);
    @(negedge clk);
    if (!port) begin
      a_req_valid = 1'b1; a_opcode = opc;
      a_op1 = x; a_op2 = y;
    end else begin
      b_req_valid = 1'b1; b_opcode = opc;
      b_op1 = x; b_op2 = y;
    end
    #1;
    chk({tag, "_rdy"},
        port ? b_req_ready : a_req_ready, 1);
    @(negedge clk);
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    #1;
    chk({tag, "_exec_vld"},
        port ? b_rsp_valid : a_rsp_valid, 0);
    @(negedge clk);
    #1;
    chk({tag, "_vld"},
        port ? b_rsp_valid : a_rsp_valid, 1);
    chk({tag, "_data"},
        port ? b_rsp_data : a_rsp_data, exp);
    chk({tag, "_err"},
        port ? b_rsp_err : a_rsp_err, err);
    chk({tag, "_other_data"},
        port ? a_rsp_data : b_rsp_data, 0);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_a_vld", a_rsp_valid, 0);
    chk("rst_b_vld", b_rsp_valid, 0);
    chk("rst_a_rdy", a_req_ready, 0);
    chk("rst_a_data", a_rsp_data, 0);
    chk("rst_a_err", a_rsp_err, 0);
    rst = 1'b0;

    run_op(0, 3'd0, 8'h3C, 8'h14, 8'h50, 0, "add");
    @(negedge clk);
    #1;
    chk("add_done_vld", a_rsp_valid, 0);
    chk("add_done_busy", busy, 0);

    run_op(1, 3'd1, 8'h05, 8'h07, 8'hFE, 0, "sub");
    run_op(1, 3'd2, 8'hFF, 8'h00, 8'h00, 0, "inc");
    run_op(1, 3'd3, 8'h00, 8'h00, 8'hFF, 0, "dec");
    run_op(0, 3'd4, 8'hA5, 8'h0F, 8'h05, 0, "and");
    run_op(1, 3'd5, 8'hA5, 8'h0F, 8'hAF, 0, "or");
    run_op(0, 3'd6, 8'hA5, 8'h0F, 8'h5A, 0, "not");
    run_op(0, 3'd7, 8'h12, 8'h34, 8'h00, 1, "ill");

    // both ports always requesting
    do_reset();
    a_req_valid = 1'b1; a_opcode = 3'd0;
    b_req_valid = 1'b1; b_opcode = 3'd1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr%0d_a", i),
          a_req_ready, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("rr%0d_b", i),
          b_req_ready, (i % 2 == 1) ? 1 : 0);
      chk($sformatf("fp%0d_a", i),
          f_a_req_ready, 1);
      chk($sformatf("fp%0d_b", i),
          f_b_req_ready, 0);
      repeat (3) @(negedge clk);
    end

    // backpressure on A while B waits
    do_reset();
    a_req_valid = 1'b1; a_opcode = 3'd0;
    a_op1 = 8'h01; a_op2 = 8'h02;
    b_req_valid = 1'b1; b_opcode = 3'd5;
    b_op1 = 8'h10; b_op2 = 8'h01;
    a_rsp_ready = 1'b0;
    #1;
    chk("bp_a_rdy", a_req_ready, 1);
    @(negedge clk);
    a_req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("bp%0d_vld", i), a_rsp_valid, 1);
      chk($sformatf("bp%0d_data", i), a_rsp_data, 8'h03);
      chk($sformatf("bp%0d_brdy", i), b_req_ready, 0);
    end
    @(negedge clk);
    a_rsp_ready = 1'b1;
    #1;
    chk("bp_hs_vld", a_rsp_valid, 1);
    chk("bp_hs_brdy", b_req_ready, 0);
    @(negedge clk);
    a_rsp_ready = 1'b0;
    #1;
    chk("bp_b_grant", b_req_ready, 1);
    @(negedge clk);
    b_req_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("bp_b_vld", b_rsp_valid, 1);
    chk("bp_b_data", b_rsp_data, 8'h11);

    // reset during EXEC drops the operation
    do_reset();
    a_req_valid = 1'b1; a_opcode = 3'd0;
    a_op1 = 8'h22; a_op2 = 8'h11;
    #1;
    chk("mr_rdy", a_req_ready, 1);
    @(negedge clk);
    a_req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_vld", a_rsp_valid, 0);
    chk("mr_data", a_rsp_data, 0);
    chk("mr_err", a_rsp_err, 0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("mr_vld2", a_rsp_valid, 0);
    chk("mr_busy2", busy, 0);

`ifdef ALU_ARB_ZERO_FLAG_EN
    run_op(0, 3'd4, 8'hF0, 8'h0F, 8'h00, 0, "zand");
    chk("zand_zero", a_rsp_zero, 1);
    run_op(0, 3'd0, 8'h01, 8'h01, 8'h02, 0, "zadd");
    chk("zadd_zero", a_rsp_zero, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
